blit_write_combiner: RTL

BLIT_WRITE_COMBINER -- requirements
Module: blit_write_combiner

---
 rtl/blit_write_combiner_if.sv | 26 ++
 rtl/blit_write_combiner.sv | 121 ++++++++++++
 2 files changed

// File: rtl/blit_write_combiner_if.sv
// Pixel-write and word-request signal bundle for the blit write combiner.
// slave is the combiner's view; master is the blitter/memory side driving it.
interface blit_write_combiner_if;
  logic        p4_write;
  logic [25:0] p4_address;
  logic [7:0]  p4_wdata;
  logic        p4_flush;
  logic        stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [25:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        idle;
  logic        overflow;

  modport master (
    output p4_write, p4_address, p4_wdata, p4_flush, mem_ready,
    input  stall, mem_valid, mem_address, mem_wdata, mem_wmask, idle, overflow
  );

  modport slave (
    input  p4_write, p4_address, p4_wdata, p4_flush, mem_ready,
    output stall, mem_valid, mem_address, mem_wdata, mem_wmask, idle, overflow
  );
endinterface

// File: rtl/blit_write_combiner.sv
// Gathers byte pixel writes into masked 32-bit word writes; a completed word or flush is requested one cycle later.
// mem_valid/mem_ready pop a small FIFO; stall is advisory, and a push into a full FIFO is dropped and sets sticky overflow.
module blit_write_combiner #(
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_LEVEL = 2
) (
  input logic                   clock,
  input logic                   reset,
  blit_write_combiner_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  logic          acc_valid;
  logic [23:0]   acc_addr;
  logic [31:0]   acc_data;
  logic [3:0]    acc_mask;
  logic          pend_flush;
  entry_t        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, next_count;
  logic          stall_q, overflow_q;

  logic          nxt_valid, nxt_pend, push, push_ok, pop, full, flush_req, same_word, mem_valid_int;
  logic [23:0]   nxt_addr;
  logic [31:0]   nxt_data, lane_data, lane_bits, merge_data;
  logic [3:0]    nxt_mask, lane_mask, merge_mask;
  entry_t        push_entry, head;

  always_comb begin
    lane_mask  = 4'b0001 << bus.p4_address[1:0];
    lane_data  = {24'b0, bus.p4_wdata} << {bus.p4_address[1:0], 3'b000};
    lane_bits  = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    flush_req  = bus.p4_flush | pend_flush;
    same_word  = acc_valid && (bus.p4_address[25:2] == acc_addr);
    // An empty gather register merges against zeroes, which is the same as a fresh load.
    merge_mask = (same_word ? acc_mask : 4'b0) | lane_mask;
    merge_data = ((same_word ? acc_data : 32'b0) & ~lane_bits) | lane_data;
    push       = 1'b0;
    push_entry = '{addr: acc_addr, data: acc_data, mask: acc_mask};
    nxt_valid  = acc_valid;
    nxt_addr   = acc_addr;
    nxt_data   = acc_data;
    nxt_mask   = acc_mask;
    nxt_pend   = 1'b0;
    if (bus.p4_write) begin
      if (acc_valid && !same_word) begin
        // One push per cycle: the old word goes now, the new byte waits and inherits the flush.
        push      = 1'b1;
        nxt_valid = 1'b1;
        nxt_addr  = bus.p4_address[25:2];
        nxt_data  = lane_data;
        nxt_mask  = lane_mask;
        nxt_pend  = flush_req;
      end else if (merge_mask == 4'b1111 || flush_req) begin
        push       = 1'b1;
        push_entry = '{addr: bus.p4_address[25:2], data: merge_data, mask: merge_mask};
        nxt_valid  = 1'b0;
      end else begin
        nxt_valid = 1'b1;
        nxt_addr  = bus.p4_address[25:2];
        nxt_data  = merge_data;
        nxt_mask  = merge_mask;
      end
    end else if (flush_req && acc_valid) begin
      push      = 1'b1;
      nxt_valid = 1'b0;
    end
  end

  assign mem_valid_int = (count != '0) && !reset;
  assign pop           = mem_valid_int && bus.mem_ready;
  assign full          = (count == CW'(FIFO_DEPTH));
  assign push_ok       = push && (!full || pop);
  assign next_count    = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_valid  <= 1'b0;
      acc_addr   <= '0;
      acc_data   <= '0;
      acc_mask   <= '0;
      pend_flush <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      acc_valid  <= nxt_valid;
      acc_addr   <= nxt_addr;
      acc_data   <= nxt_data;
      acc_mask   <= nxt_mask;
      pend_flush <= nxt_pend;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= next_count;
      stall_q <= (next_count >= CW'(STALL_LEVEL));
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign head            = fifo_mem[rd_ptr];
  assign bus.mem_valid   = mem_valid_int;
  assign bus.mem_address = {head.addr, 2'b00};
  assign bus.mem_wdata   = head.data;
  assign bus.mem_wmask   = head.mask;
  assign bus.stall       = stall_q;
  assign bus.overflow    = overflow_q;
  assign bus.idle        = !acc_valid && (count == '0) && !bus.p4_write && !pend_flush;
endmodule
